// File: rtl/msg_pkg.sv
// Shared definitions for the message packer, the User outgoing side and benches.
// Character width, default capacity, line-feed code and packer state encoding.
package msg_pkg;

  localparam int unsigned      CHAR_W        = 8;
  localparam int unsigned      MSG_BYTES_DEF = 100;
  localparam logic [CHAR_W-1:0] CHAR_LF      = 8'h0A;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/msg_packer.sv
// Packs a valid/ready byte stream into a right-justified line-style message word.
// Optional: define MSG_PACKER_NEWLINE_TERM_EN to make 0x0A terminate (and not store) a line.
module msg_packer
  import msg_pkg::*;
#(
  parameter int unsigned MSG_BYTES = MSG_BYTES_DEF
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHAR_W-1:0]               in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [CHAR_W*MSG_BYTES:1]       msg_out,
  output logic [$clog2(MSG_BYTES+1)-1:0]  msg_len,
  output logic                            msg_valid,
  input  logic                            msg_ack,
  output logic                            overflow
);

  localparam int unsigned      LEN_W    = $clog2(MSG_BYTES + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MSG_BYTES);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MSG_BYTES - 1);

  state_t                     state_q, state_d;
  logic [CHAR_W*MSG_BYTES:1]  msg_q;
  logic [LEN_W-1:0]           len_q;
  logic                       ovf_q;

  logic accept;
  logic is_lf;
  logic term;
  logic store;
  logic clr;
  logic set_ovf;

`ifdef MSG_PACKER_NEWLINE_TERM_EN
  assign is_lf = (in_data == CHAR_LF);
`else
  assign is_lf = 1'b0;
`endif

  // Handshake flags come from the state register only, never from inputs.
  assign in_ready  = (state_q != HOLD);
  assign msg_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign term      = in_last || is_lf;

  always_comb begin
    state_d = state_q;
    store   = 1'b0;
    clr     = 1'b0;
    set_ovf = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          store = !is_lf;
          if (term) begin
            state_d = HOLD;
          end else if (len_q == LEN_LAST) begin
            state_d = DRAIN;
            set_ovf = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && term) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (msg_ack) begin
          state_d = FILL;
          clr     = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      msg_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        msg_q <= '0;
        len_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (store) begin
          msg_q <= {msg_q[CHAR_W*MSG_BYTES-CHAR_W:1], in_data};
          if (len_q != LEN_MAX) begin
            len_q <= len_q + LEN_W'(1);
          end
        end
        if (set_ovf) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign msg_out  = msg_q;
  assign msg_len  = len_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_msg_packer.sv
// Directed self-checking bench for msg_packer; newline tests follow MSG_PACKER_NEWLINE_TERM_EN.
module tb_msg_packer;
  import msg_pkg::*;

  localparam int unsigned NB = 100;

  logic            clock = 1'b0;
  logic            reset;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [8*NB:1]   msg_out;
  logic [6:0]      msg_len;
  logic            msg_valid;
  logic            msg_ack;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  msg_packer #(.MSG_BYTES(NB)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .msg_out   (msg_out),
    .msg_len   (msg_len),
    .msg_valid (msg_valid),
    .msg_ack   (msg_ack),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic last);
    @(negedge clock);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ack();
    @(negedge clock);
    msg_ack = 1'b1;
    @(posedge clock);
    #1;
    msg_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if (msg_out !== '0 || msg_len !== 7'd0 || msg_valid !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: len=%0d valid=%b ovf=%b ready=%b out_nonzero=%b, need 0/0/0/1/0",
               msg_len, msg_valid, overflow, in_ready, |msg_out);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_hi();
    logic [8*NB:1] exp;
    exp = '0;
    exp[16:1] = 16'h4849;
    send(8'h48, 1'b0);
    checks++;
    if (msg_valid !== 1'b0 || msg_len !== 7'd1) begin
      errors++;
      $display("FAIL hi_first: valid=%b len=%0d, need 0 and 1", msg_valid, msg_len);
    end
    send(8'h49, 1'b1);
    checks++;
    if (msg_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hi_valid_latency: valid=%b ready=%b, need 1 and 0", msg_valid, in_ready);
    end
    checks++;
    if (msg_out !== exp || msg_len !== 7'd2) begin
      errors++;
      $display("FAIL hi_data: out[16:1]=%h len=%0d upper_nonzero=%b, need 4849 len 2",
               msg_out[16:1], msg_len, |msg_out[8*NB:17]);
    end
    ack();
    checks++;
    if (msg_out !== '0 || msg_len !== 7'd0 || msg_valid !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hi_after_ack: len=%0d valid=%b ovf=%b ready=%b, need 0/0/0/1",
               msg_len, msg_valid, overflow, in_ready);
    end
  endtask

  task automatic test_full100();
    logic [8*NB:1] exp;
    exp = {NB{8'h41}};
    for (int i = 0; i < 100; i++) send(8'h41, (i == 99));
    checks++;
    if (msg_len !== 7'd100 || overflow !== 1'b0 || msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL full100_flags: len=%0d ovf=%b valid=%b, need 100/0/1", msg_len, overflow, msg_valid);
    end
    checks++;
    if (msg_out !== exp) begin
      errors++;
      $display("FAIL full100_data: top=%h bottom=%h, need all bytes 41", msg_out[800:793], msg_out[8:1]);
    end
    ack();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 100; i++) send(8'(8'h30 + i), 1'b0);
    checks++;
    if (in_ready !== 1'b1 || msg_valid !== 1'b0 || overflow !== 1'b1 || msg_len !== 7'd100) begin
      errors++;
      $display("FAIL ovf_drain_entry: ready=%b valid=%b ovf=%b len=%0d, need 1/0/1/100",
               in_ready, msg_valid, overflow, msg_len);
    end
    send(8'h94, 1'b0);
    send(8'h95, 1'b0);
    send(8'h96, 1'b1);
    checks++;
    // 100th accepted byte is 0x30+99 = 0x93; the three drained bytes never land.
    if (msg_valid !== 1'b1 || overflow !== 1'b1 || msg_len !== 7'd100 ||
        msg_out[8:1] !== 8'h93 || msg_out[800:793] !== 8'h30) begin
      errors++;
      $display("FAIL ovf_hold: valid=%b ovf=%b len=%0d low=%h high=%h, need 1/1/100/93/30",
               msg_valid, overflow, msg_len, msg_out[8:1], msg_out[800:793]);
    end
    ack();
    checks++;
    if (overflow !== 1'b0 || msg_len !== 7'd0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b len=%0d, need 0 and 0", overflow, msg_len);
    end
  endtask

  task automatic test_hold_stall();
    logic [8*NB:1] exp;
    exp = '0;
    exp[16:1] = 16'h5566;
    send(8'h55, 1'b0);
    send(8'h66, 1'b1);
    @(negedge clock);
    in_data  = 8'h77;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0 || msg_out !== exp || msg_len !== 7'd2) begin
        errors++;
        $display("FAIL hold_stall_%0d: ready=%b out[16:1]=%h len=%0d, need 0/5566/2",
                 i, in_ready, msg_out[16:1], msg_len);
      end
    end
    msg_ack = 1'b1;
    @(posedge clock);
    #1;
    msg_ack = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || msg_len !== 7'd0 || msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack_turn: ready=%b len=%0d valid=%b, need 1/0/0", in_ready, msg_len, msg_valid);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (msg_valid !== 1'b1 || msg_len !== 7'd1 || msg_out[8:1] !== 8'h77) begin
      errors++;
      $display("FAIL hold_pending_byte: valid=%b len=%0d low=%h, need 1/1/77", msg_valid, msg_len, msg_out[8:1]);
    end
    ack();
  endtask

  task automatic test_async_reset();
    logic [8*NB:1] exp;
    exp = '0;
    exp[16:1] = 16'h4F4B;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (msg_out !== '0 || msg_len !== 7'd0 || msg_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: len=%0d valid=%b ready=%b out_nonzero=%b, need 0/0/1/0",
               msg_len, msg_valid, in_ready, |msg_out);
    end
    reset = 1'b0;
    send(8'h4F, 1'b0);
    send(8'h4B, 1'b1);
    checks++;
    if (msg_out !== exp || msg_len !== 7'd2 || msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_then_ok: out[16:1]=%h len=%0d valid=%b, need 4F4B/2/1",
               msg_out[16:1], msg_len, msg_valid);
    end
    ack();
  endtask

`ifdef MSG_PACKER_NEWLINE_TERM_EN
  task automatic test_newline();
    logic [8*NB:1] exp;
    exp = '0;
    exp[8:1] = 8'h41;
    send(8'h41, 1'b0);
    send(CHAR_LF, 1'b0);
    checks++;
    if (msg_valid !== 1'b1 || msg_len !== 7'd1 || msg_out !== exp) begin
      errors++;
      $display("FAIL nl_line: valid=%b len=%0d low=%h, need 1/1/41", msg_valid, msg_len, msg_out[8:1]);
    end
    ack();
    send(CHAR_LF, 1'b0);
    checks++;
    if (msg_valid !== 1'b1 || msg_len !== 7'd0 || msg_out !== '0) begin
      errors++;
      $display("FAIL nl_empty: valid=%b len=%0d out_nonzero=%b, need 1/0/0", msg_valid, msg_len, |msg_out);
    end
    ack();
  endtask
`else
  task automatic test_newline();
    logic [8*NB:1] exp;
    exp = '0;
    exp[16:1] = 16'h0A42;
    send(CHAR_LF, 1'b0);
    checks++;
    if (msg_valid !== 1'b0 || msg_len !== 7'd1) begin
      errors++;
      $display("FAIL lf_is_data: valid=%b len=%0d, need 0 and 1", msg_valid, msg_len);
    end
    send(8'h42, 1'b1);
    checks++;
    if (msg_valid !== 1'b1 || msg_len !== 7'd2 || msg_out !== exp) begin
      errors++;
      $display("FAIL lf_data_msg: valid=%b len=%0d out[16:1]=%h, need 1/2/0A42",
               msg_valid, msg_len, msg_out[16:1]);
    end
    ack();
  endtask
`endif

  task automatic test_ack_outside_hold();
    @(negedge clock);
    msg_ack = 1'b1;
    in_last = 1'b1;
    @(posedge clock);
    #1;
    msg_ack = 1'b0;
    in_last = 1'b0;
    send(8'h5A, 1'b0);
    checks++;
    if (msg_valid !== 1'b0 || msg_len !== 7'd1 || msg_out[8:1] !== 8'h5A) begin
      errors++;
      $display("FAIL stray_ack_last: valid=%b len=%0d low=%h, need 0/1/5A", msg_valid, msg_len, msg_out[8:1]);
    end
    send(8'h5B, 1'b1);
    ack();
  endtask

  initial begin
    reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    msg_ack  = 1'b0;
    test_reset();
    test_hi();
    test_full100();
    test_overflow();
    test_hold_stall();
    test_async_reset();
    test_newline();
    test_ack_outside_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
